prach_hb_interp: RTL and testbench



---
 rtl/prach_duc_pkg.sv | 20 ++
 rtl/prach_hb_interp_if.sv | 17 +
 rtl/prach_hb_interp_hist.sv | 28 ++
 rtl/prach_hb_interp.sv | 84 ++++++++
 tb/tb_prach_hb_interp.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/prach_duc_pkg.sv
// prach_duc_pkg: shared widths, half-band coefficients and output rounding for the PRACH DUC stages.
package prach_duc_pkg;
    localparam int DW = 16;
    localparam int CW = 18;
    localparam int AW = 37;
    localparam int PW = DW + 1;
    localparam int MW = PW + CW;
    localparam int LATENCY = 4;
    localparam logic signed [CW-1:0] HB_COEF [4] = '{18'sd79100, -18'sd17400, 18'sd4900, -18'sd1064};
    localparam logic signed [AW-1:0] RND_HALF = 37'sd65536;
    localparam logic signed [AW-1:0] SAT_MAX = 37'sd32767;
    localparam logic signed [AW-1:0] SAT_MIN = -37'sd32768;

    // Round half-up at 2^17 then clamp to the 16-bit signed range.
    function automatic logic signed [DW-1:0] rnd_sat(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] r;
        r = (acc + RND_HALF) >>> 17;
        return (r > SAT_MAX) ? 16'sh7fff : (r < SAT_MIN) ? 16'sh8000 : r[DW-1:0];
    endfunction
endpackage

// File: rtl/prach_hb_interp_if.sv
// prach_hb_interp_if: TDM sample input and 2-lane polyphase output of the half-band interpolator.
interface prach_hb_interp_if;
    import prach_duc_pkg::*;
    logic signed [DW-1:0] din_dq;
    logic                 din_dv;
    logic [7:0]           din_chn;
    logic                 sync_in;
    logic signed [DW-1:0] dout_dp1;
    logic signed [DW-1:0] dout_dp2;
    logic                 dout_dv;
    logic [7:0]           dout_chn;
    logic                 sync_out;
    modport master (output din_dq, din_dv, din_chn, sync_in,
                    input dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out);
    modport slave (input din_dq, din_dv, din_chn, sync_in,
                   output dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out);
endinterface

// File: rtl/prach_hb_interp_hist.sv
// prach_hb_interp_hist: per-channel 7-deep sample history, shift-on-write with global clear.
module prach_hb_interp_hist
    import prach_duc_pkg::*;
#(
    parameter int NUM_CHN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             wr_i,
    input  logic [7:0]       chn_i,
    input  logic [DW-1:0]    din_i,
    output logic [7*DW-1:0]  hist_o
);
    localparam int IW = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
    // Slot k holds x[n-1-k]; the newest sample enters at the low end.
    logic [7*DW-1:0] mem_q [NUM_CHN];
    assign hist_o = mem_q[chn_i[IW-1:0]];
    for (genvar c = 0; c < NUM_CHN; c++) begin : g_chn
        logic hit;
        assign hit = wr_i && (chn_i == 8'(c));
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) mem_q[c] <= '0;
            else if (clr_i) mem_q[c] <= hit ? {{6*DW{1'b0}}, din_i} : '0;
            else if (hit) mem_q[c] <= {mem_q[c][6*DW-1:0], din_i};
        end
    end
endmodule

// File: rtl/prach_hb_interp.sv
// prach_hb_interp: multichannel TDM half-band interpolate-by-2, 4-stage pipeline
// (pre-add, multiply, sum, round/saturate) producing even and odd phases in parallel.
module prach_hb_interp
    import prach_duc_pkg::*;
#(
    parameter int NUM_CHN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    prach_hb_interp_if.slave  bus
);
    logic                 acc_d;
    logic                 clr_d;
    logic [7*DW-1:0]      hist;
    logic signed [DW-1:0] h_d [7];
    logic signed [PW-1:0] pa_d [4];
    logic signed [PW-1:0] pa_q [4];
    logic signed [MW-1:0] pr_q [4];
    logic signed [AW-1:0] acc_q;
    logic signed [DW-1:0] dp1_q [3];
    logic [7:0]           chn_q [3];
    logic [2:0]           dv_q;
    logic [2:0]           sy_q;

    assign acc_d = bus.din_dv && ({1'b0, bus.din_chn} < 9'(NUM_CHN));
    assign clr_d = bus.din_dv && bus.sync_in;

    prach_hb_interp_hist #(.NUM_CHN(NUM_CHN)) u_hist (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr_d),
        .wr_i   (acc_d),
        .chn_i  (bus.din_chn),
        .din_i  (bus.din_dq),
        .hist_o (hist)
    );

    // A sync sample must see zero history even though the clear lands on this same edge.
    always_comb begin
        for (int k = 0; k < 7; k++) h_d[k] = clr_d ? '0 : hist[k*DW +: DW];
        pa_d[0] = PW'(h_d[2]) + PW'(h_d[3]);
        pa_d[1] = PW'(h_d[1]) + PW'(h_d[4]);
        pa_d[2] = PW'(h_d[0]) + PW'(h_d[5]);
        pa_d[3] = PW'(bus.din_dq) + PW'(h_d[6]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pa_q         <= '{default: '0};
            pr_q         <= '{default: '0};
            dp1_q        <= '{default: '0};
            chn_q        <= '{default: '0};
            acc_q        <= '0;
            dv_q         <= '0;
            sy_q         <= '0;
            bus.dout_dp1 <= '0;
            bus.dout_dp2 <= '0;
            bus.dout_dv  <= 1'b0;
            bus.dout_chn <= '0;
            bus.sync_out <= 1'b0;
        end else begin
            dv_q     <= {dv_q[1:0], acc_d};
            sy_q     <= {sy_q[1:0], clr_d};
            chn_q[0] <= bus.din_chn;
            chn_q[1] <= chn_q[0];
            chn_q[2] <= chn_q[1];
            dp1_q[0] <= h_d[3];
            dp1_q[1] <= dp1_q[0];
            dp1_q[2] <= dp1_q[1];
            for (int k = 0; k < 4; k++) begin
                pa_q[k] <= pa_d[k];
                pr_q[k] <= pa_q[k] * HB_COEF[k];
            end
            acc_q        <= AW'(pr_q[0]) + AW'(pr_q[1]) + AW'(pr_q[2]) + AW'(pr_q[3]);
            bus.dout_dv  <= dv_q[2];
            bus.sync_out <= sy_q[2];
            if (dv_q[2]) begin
                bus.dout_dp1 <= dp1_q[2];
                bus.dout_dp2 <= rnd_sat(acc_q);
                bus.dout_chn <= chn_q[2];
            end
        end
    end
endmodule

// File: tb/tb_prach_hb_interp.sv
// tb_prach_hb_interp: scoreboard bench for the half-band interpolator; expected outputs
// come from a per-channel behavioural model when each sample is driven.
module tb_prach_hb_interp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prach_hb_interp_if bus ();
    prach_hb_interp #(.NUM_CHN(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int         cyc;
        logic       dv;
        logic       sy;
        logic [7:0] chn;
        int         dp1;
        int         dp2;
    } exp_t;

    exp_t sb[$];
    int   hist_m [8][7];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_dp1, last_dp2, last_sy;
    int   ch_dp1 [8];
    int   ch_dp2 [8];
    int   cap1[$];
    int   cap2[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus.dout_dv || bus.sync_out)) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output cyc=%0d dv=%b sync=%b chn=%0d", cyc, bus.dout_dv, bus.sync_out, bus.dout_chn);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.cyc || bus.dout_dv !== e.dv || bus.sync_out !== e.sy ||
                    (e.dv && (bus.dout_chn !== e.chn || int'(bus.dout_dp1) !== e.dp1 || int'(bus.dout_dp2) !== e.dp2))) begin
                    failures++;
                    $display("FAIL output got cyc=%0d dv=%b sy=%b chn=%0d dp1=%0d dp2=%0d expected cyc=%0d dv=%b sy=%b chn=%0d dp1=%0d dp2=%0d",
                             cyc, bus.dout_dv, bus.sync_out, bus.dout_chn, int'(bus.dout_dp1), int'(bus.dout_dp2),
                             e.cyc, e.dv, e.sy, e.chn, e.dp1, e.dp2);
                end
            end
            last_sy = int'(bus.sync_out);
            if (bus.dout_dv) begin
                last_dp1 = int'(bus.dout_dp1);
                last_dp2 = int'(bus.dout_dp2);
                ch_dp1[bus.dout_chn[2:0]] = last_dp1;
                ch_dp2[bus.dout_chn[2:0]] = last_dp2;
                if (bus.dout_chn == 8'd0) begin
                    cap1.push_back(last_dp1);
                    cap2.push_back(last_dp2);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int chn, input int d, input bit sy);
        int  c [4];
        int  h [7];
        bit  ok;
        longint a;
        exp_t e;
        c = '{79100, -17400, 4900, -1064};
        @(negedge clk);
        bus.din_dq  = 16'(d);
        bus.din_chn = 8'(chn);
        bus.sync_in = sy;
        bus.din_dv  = 1'b1;
        ok = (chn < 8);
        if (sy) hist_m = '{default: 0};
        if (ok || sy) begin
            e.cyc = cyc + 4;
            e.dv  = ok;
            e.sy  = sy;
            e.chn = 8'(chn);
            e.dp1 = 0;
            e.dp2 = 0;
            if (ok) begin
                h = hist_m[chn];
                a = longint'(c[3]) * (d + h[6]) + longint'(c[2]) * (h[0] + h[5]) +
                    longint'(c[1]) * (h[1] + h[4]) + longint'(c[0]) * (h[2] + h[3]);
                a = (a + 65536) >>> 17;
                if (a > 32767) a = 32767;
                if (a < -32768) a = -32768;
                e.dp1 = h[3];
                e.dp2 = int'(a);
                for (int k = 6; k > 0; k--) hist_m[chn][k] = hist_m[chn][k-1];
                hist_m[chn][0] = d;
            end
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.din_dv  = 1'b0;
            bus.sync_in = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.dout_dv !== 1'b0 || bus.sync_out !== 1'b0 || bus.dout_dp1 !== 16'sd0 ||
            bus.dout_dp2 !== 16'sd0 || bus.dout_chn !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs got dv=%b sy=%b dp1=%0d dp2=%0d chn=%0d required all 0",
                     bus.dout_dv, bus.sync_out, bus.dout_dp1, bus.dout_dp2, bus.dout_chn);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_impulse();
        int exp2 [8];
        exp2 = '{-133, 613, -2175, 9888, 9888, -2175, 613, -133};
        cap1.delete();
        cap2.delete();
        drive(0, 16384, 1'b0);
        repeat (11) drive(0, 0, 1'b0);
        drain();
        checks++;
        if (cap2.size() < 8) begin
            failures++;
            $display("FAIL impulse_count got=%0d required>=8", cap2.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (cap2[i] !== exp2[i] || cap1[i] !== ((i == 4) ? 16384 : 0)) begin
                    failures++;
                    $display("FAIL impulse_%0d got dp1=%0d dp2=%0d required dp1=%0d dp2=%0d",
                             i, cap1[i], cap2[i], (i == 4) ? 16384 : 0, exp2[i]);
                end
            end
        end
    endtask

    task automatic test_dc_tdm();
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) drive(k, 1000 * (k + 1), (r == 0) && (k == 0));
        drain();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (ch_dp1[k] !== 1000 * (k + 1) || ch_dp2[k] !== 1000 * (k + 1)) begin
                failures++;
                $display("FAIL dc_chn%0d got dp1=%0d dp2=%0d required %0d", k, ch_dp1[k], ch_dp2[k], 1000 * (k + 1));
            end
        end
    endtask

    task automatic test_saturation();
        int p [8];
        p = '{-32768, 32767, -32768, 32767, 32767, -32768, 32767, -32768};
        for (int i = 0; i < 8; i++) drive(0, p[i], i == 0);
        drain();
        checks++;
        if (last_dp2 !== 32767) begin
            failures++;
            $display("FAIL sat_pos got dp2=%0d required 32767", last_dp2);
        end
        for (int i = 0; i < 8; i++) drive(0, (p[i] == 32767) ? -32768 : 32767, i == 0);
        drain();
        checks++;
        if (last_dp2 !== -32768) begin
            failures++;
            $display("FAIL sat_neg got dp2=%0d required -32768", last_dp2);
        end
    endtask

    task automatic test_sync_clear();
        repeat (3) drive(1, 700, 1'b0);
        repeat (10) drive(3, 5000, 1'b0);
        drive(3, 0, 1'b1);
        drain();
        checks++;
        if (last_dp1 !== 0 || last_dp2 !== 0 || last_sy !== 1) begin
            failures++;
            $display("FAIL sync_clear got dp1=%0d dp2=%0d sync=%0d required 0 0 1", last_dp1, last_dp2, last_sy);
        end
        drive(1, 100, 1'b0);
        drain();
        checks++;
        if (last_dp1 !== 0 || last_dp2 !== -1) begin
            failures++;
            $display("FAIL sync_other_chn got dp1=%0d dp2=%0d required 0 -1", last_dp1, last_dp2);
        end
    endtask

    task automatic test_illegal();
        int d [6];
        int a1, a2;
        d = '{1111, 2222, -3333, 4444, 555, -6666};
        for (int i = 0; i < 6; i++) drive(0, d[i], i == 0);
        drain();
        a1 = last_dp1;
        a2 = last_dp2;
        for (int i = 0; i < 6; i++) begin
            drive(0, d[i], i == 0);
            if (i == 3) drive(8, 7777, 1'b0);
        end
        drain();
        checks++;
        if (last_dp1 !== a1 || last_dp2 !== a2) begin
            failures++;
            $display("FAIL illegal_chn got dp1=%0d dp2=%0d required %0d %0d", last_dp1, last_dp2, a1, a2);
        end
        drive(8, 5, 1'b1);
        drive(0, 1000, 1'b0);
        drain();
    endtask

    task automatic test_reset_midstream();
        drive(0, 3000, 1'b1);
        drive(0, 4000, 1'b0);
        drive(0, 5000, 1'b0);
        @(negedge clk);
        bus.din_dv = 1'b0;
        bus.sync_in = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        hist_m = '{default: 0};
        @(negedge clk);
        checks++;
        if (bus.dout_dv !== 1'b0 || bus.dout_dp1 !== 16'sd0 || bus.dout_dp2 !== 16'sd0) begin
            failures++;
            $display("FAIL midstream_reset got dv=%b dp1=%0d dp2=%0d required 0", bus.dout_dv, bus.dout_dp1, bus.dout_dp2);
        end
        rst_n = 1'b1;
        idle(8);
        test_impulse();
    endtask

    initial begin
        bus.din_dq  = '0;
        bus.din_dv  = 1'b0;
        bus.din_chn = '0;
        bus.sync_in = 1'b0;
        test_reset();
        test_impulse();
        test_dc_tdm();
        test_saturation();
        test_sync_clear();
        test_illegal();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
